// File: rtl/cam_pixel_stream.sv
// Camera byte bus to 32-bit pixel stream: byte pairing, format expansion, sof/eol tagging,
// per-frame geometry counters and a small first-word-fall-through pixel FIFO.
module cam_pixel_stream #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 11
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             href,
  input  logic [7:0]       d,
  input  logic [1:0]       mode,
  output logic [31:0]      out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] line_width,
  output logic [CNT_W-1:0] frame_lines,
  output logic             overflow,
  output logic             odd_byte
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FMT_RGB444, FMT_RGB555, FMT_RGB565, FMT_Y8} fmt_e;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [31:0] data;
  } entry_t;

  function automatic logic [23:0] map_pixel(input fmt_e fmt, input logic [15:0] p);
    map_pixel = '0;
    case (fmt)
      FMT_RGB444: map_pixel = {p[11:8], 4'h0, p[7:4], 4'h0, p[3:0], 4'h0};
      FMT_RGB555: map_pixel = {p[14:10], 3'b0, p[9:5], 3'b0, p[4:0], 3'b0};
      FMT_RGB565: map_pixel = {p[15:11], 3'b0, p[10:5], 2'b0, p[4:0], 3'b0};
      default:    map_pixel = {p[15:8], p[15:8], p[15:8]};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             vsync_q, vsync_qq, href_q, href_qq;
  logic [7:0]       d_q, a_r;
  fmt_e             mode_r;
  logic             phase, sof_pend;
  logic             stg_v, stg_sof;
  logic [23:0]      stg_data;
  logic [CNT_W-1:0] x_cnt, y_cnt, y_next;

  logic             vs_rise, vs_fall, h_fall, pix_done, flush, push;
  entry_t           push_entry;

  assign vs_rise    = vsync_q & ~vsync_qq;
  assign vs_fall    = ~vsync_q & vsync_qq;
  assign h_fall     = ~href_q & href_qq;
  assign pix_done   = href_q & phase;
  assign flush      = stg_v & (vs_rise | h_fall);
  assign push       = flush | (pix_done & stg_v);
  assign push_entry = '{sof: stg_sof, eol: flush, data: {8'h00, stg_data}};
  assign y_next     = (push && flush) ? sat_inc(y_cnt) : y_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      vsync_qq    <= 1'b0;
      href_q      <= 1'b0;
      href_qq     <= 1'b0;
      d_q         <= '0;
      a_r         <= '0;
      mode_r      <= FMT_RGB444;
      phase       <= 1'b0;
      sof_pend    <= 1'b0;
      stg_v       <= 1'b0;
      stg_sof     <= 1'b0;
      stg_data    <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      line_width  <= '0;
      frame_lines <= '0;
      odd_byte    <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      href_qq  <= href_q;
      d_q      <= d;

      if (vsync_q) mode_r <= fmt_e'(mode);

      if (!href_q) begin
        phase <= 1'b0;
      end else begin
        phase <= ~phase;
        if (!phase) a_r <= d_q;
      end
      if (h_fall && phase) odd_byte <= 1'b1;

      // sof is armed by the frame start and consumed by the first assembled pixel.
      if (vs_fall)       sof_pend <= 1'b1;
      else if (pix_done) sof_pend <= 1'b0;

      if (pix_done) begin
        stg_v    <= 1'b1;
        stg_sof  <= sof_pend;
        stg_data <= map_pixel(mode_r, {a_r, d_q});
      end else if (flush) begin
        stg_v <= 1'b0;
      end

      if (push) begin
        if (flush) begin
          line_width <= sat_inc(x_cnt);
          x_cnt      <= '0;
        end else begin
          x_cnt <= sat_inc(x_cnt);
        end
      end

      if (vs_rise) begin
        frame_lines <= y_next;
        y_cnt       <= '0;
      end else begin
        y_cnt <= y_next;
      end
    end
  end

  // Pixel FIFO: storage array plus a registered head that always mirrors the oldest entry.
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          pop, full, wr_en;

  assign pop        = out_valid & out_ready;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign wr_en      = push & (~full | pop);
  assign count_next = count + CW'(wr_en) - CW'(pop);

  // NOTE: the storage array has no reset; only pointers, count and head define what is visible.
  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head      <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (push && full && !pop) overflow <= 1'b1;

      // With one entry left, a same-cycle push becomes the new head directly.
      if (pop) begin
        if (count == CW'(1)) begin
          if (wr_en) head <= push_entry;
        end else begin
          head <= mem[rd_ptr + AW'(1)];
        end
      end else if (count == '0 && wr_en) begin
        head <= push_entry;
      end
    end
  end

  assign out_data = head.data;
  assign out_sof  = head.sof;
  assign out_eol  = head.eol;

endmodule
